// File: rtl/shift_8x64_pkg.sv
// rtl/shift_8x64_pkg.sv - shared defaults, widths and state encoding for the 8x64 unload path
package shift_8x64_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 64;
    localparam int TAP1_DEF  = 15;
    localparam int TAP2_DEF  = 31;
    localparam int TAP3_DEF  = 47;

    localparam int IDX_W_DEF = $clog2(DEPTH_DEF);
    localparam int CNT_W_DEF = IDX_W_DEF + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/shift_8x64_unload_core.sv
// rtl/shift_8x64_unload_core.sv - DEPTH x WIDTH register array with parallel load and shift toward the tail
module shift_8x64_unload_core
    import shift_8x64_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     load_en,
    input  logic                     shift_en,
    input  logic [WIDTH*DEPTH-1:0]   load_data,
    output logic [WIDTH-1:0]         tail_data
);

    // Packed so entry i lines up with load_data[i*WIDTH +: WIDTH].
    logic [DEPTH-1:0][WIDTH-1:0] sr_q;
    logic [DEPTH-1:0][WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (clear) begin
            sr_d = '0;
        end else if (load_en) begin
            sr_d = load_data;
        end else if (shift_en) begin
            sr_d = {sr_q[DEPTH-2:0], {WIDTH{1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign tail_data = sr_q[DEPTH-1];

endmodule

// File: rtl/shift_8x64_unload.sv
// rtl/shift_8x64_unload.sv - frame load, serial replay FSM; SHIFT_UNLOAD_TAP_MARK_EN adds tap_hit/tap_sel
module shift_8x64_unload
    import shift_8x64_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int TAP1  = TAP1_DEF,
    parameter int TAP2  = TAP2_DEF,
    parameter int TAP3  = TAP3_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [WIDTH*DEPTH-1:0]     load_data,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_last,
`ifdef SHIFT_UNLOAD_TAP_MARK_EN
    output logic                       tap_hit,
    output logic [1:0]                 tap_sel,
`endif
    output logic [$clog2(DEPTH)-1:0]   out_index
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               load_fire;
    logic               beat_fire;

    assign load_fire = (state_q == IDLE)  && load_valid;
    assign beat_fire = (state_q == SHIFT) && out_ready;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else if (load_fire) begin
            state_d = SHIFT;
            count_d = CNT_W'(DEPTH);
        end else if (beat_fire) begin
            count_d = count_q - 1'b1;
            if (count_q == CNT_W'(1)) begin
                state_d = IDLE;
            end
        end
    end

`ifdef SHIFT_UNLOAD_TAP_MARK_EN
    logic [1:0]        tap_sel_q, tap_sel_d;
    logic [IDX_W-1:0]  next_index;

    // Marks are registered against the beat that will be presented next cycle.
    assign next_index = IDX_W'(CNT_W'(DEPTH) - count_d);

    always_comb begin
        tap_sel_d = 2'd0;
        if (state_d == SHIFT) begin
            if (next_index == IDX_W'(DEPTH - 1 - TAP1)) begin
                tap_sel_d = 2'd1;
            end else if (next_index == IDX_W'(DEPTH - 1 - TAP2)) begin
                tap_sel_d = 2'd2;
            end else if (next_index == IDX_W'(DEPTH - 1 - TAP3)) begin
                tap_sel_d = 2'd3;
            end
        end
    end

    assign tap_sel = tap_sel_q;
    assign tap_hit = (tap_sel_q != 2'd0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
`ifdef SHIFT_UNLOAD_TAP_MARK_EN
            tap_sel_q <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
`ifdef SHIFT_UNLOAD_TAP_MARK_EN
            tap_sel_q <= tap_sel_d;
`endif
        end
    end

    shift_8x64_unload_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .load_en   (load_fire),
        .shift_en  (beat_fire),
        .load_data (load_data),
        .tail_data (out_data)
    );

    assign load_ready = (state_q == IDLE);
    assign out_valid  = (state_q == SHIFT);
    assign out_last   = (state_q == SHIFT) && (count_q == CNT_W'(1));
    assign out_index  = (state_q == SHIFT) ? IDX_W'(CNT_W'(DEPTH) - count_q) : '0;

endmodule
